jk_reg_bank: RTL and testbench
==============================

// Module: jk_reg_bank
// PURPOSE
//  WIDTH-bit bank of JK flip-flops sharing one clock, one enable, a parallel-load port and selectable disable behaviour.
//  Drives a true complementary qbar and a per-bit change pulse.
//  Used as a status/flag register wherever per-bit set/clear/toggle control is needed.
// PARAMETERS
//  WIDTH     8     number of JK channels (>=1)
//  RST_VAL   '0    q value loaded by reset (WIDTH bits)
//  DIS_MODE  0     behaviour while en=0: 0 = clear q to 0, 1 = hold q
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      reset, synchronous, active-high
//  en          in   1      enable for JK operation
//  j           in   WIDTH  per-bit J
//  k           in   WIDTH  per-bit K
//  ld          in   1      parallel load strobe
//  ld_data     in   WIDTH  parallel load value
//  q           out  WIDTH  state
//  qbar        out  WIDTH  always ~q, including during and after reset
//  chg         out  WIDTH  chg[i]=1 for exactly the cycle in which q[i] shows a new value
//  sticky_clr  in   WIDTH  write-1-to-clear for sticky (JK_STICKY_EN only)
//  sticky      out  WIDTH  accumulated change flags (JK_STICKY_EN only)
//  irq         out  1      |sticky (JK_STICKY_EN only)
// BEHAVIOUR
//  - Registered, latency 1: inputs sampled at posedge N; q, chg valid after posedge N.
//  - Priority per cycle: rst > ld > en > disabled.
//  - rst=1: q<=RST_VAL, chg<=0, sticky<=0; reset itself never raises chg.
//  - ld=1 (rst=0): q<=ld_data, regardless of en, j and k.
//  - en=1, ld=0, per bit {j,k}: 00 hold; 01 q<=0; 10 q<=1; 11 q<=~q.
//  - en=0, ld=0: DIS_MODE=0 -> q<=0; DIS_MODE=1 -> q holds.
//  - chg <= q_next ^ q for every non-reset cycle, from whichever source (ld, JK, disable-clear).
//    A load of the current value gives chg=0.
//  - A reset asserted mid-sequence wins in that cycle; the pending ld/JK op is discarded.
//  - qbar is derived as ~q, never separately stored, so q and qbar cannot disagree.
//  - irq is combinational from the sticky register, with no extra latency.
// CONFIGURATION
//  - Macro JK_STICKY_EN.
//  - Defined:
//    - sticky[i] <= (sticky[i] & ~sticky_clr[i]) | chg_next[i].
//    - Set wins over a simultaneous clear.
//    - sticky_clr, sticky and irq ports exist.
//  - Undefined: those three ports and the sticky register are absent; all other behaviour is identical.
// STRUCTURE
//  - Package jk_pkg:
//    - typedef enum logic [1:0] jk_op_t {JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11};
//    - function jk_next(jk_op_t op, logic q) returning the next bit;
//    - localparam DIS_CLEAR=0, DIS_HOLD=1.
//  - Sub-module jk_cell: one bit holding q and chg, with ports clk, rst, rst_val, en, j, k, ld, ld_d, dis_mode.
//  - jk_reg_bank instantiates WIDTH jk_cell via generate and adds the optional sticky/irq logic.
// TESTING (WIDTH=8, RST_VAL=8'hA5 unless noted)
//  1. rst=1 for 2 cycles -> q=8'hA5, qbar=8'h5A, chg=0, sticky=0, irq=0.
//  2. en=1, j=8'hF0, k=8'h0F from q=8'hA5 -> q=8'hF0, chg=8'h55.
//     Next cycle j=k=8'hFF -> q=8'h0F, chg=8'hFF.
//  3. DIS_MODE=0: en=0 with q=8'h0F -> q=8'h00, chg=8'h0F.
//     DIS_MODE=1: en=0 -> q stays 8'h0F, chg=0.
//  4. ld=1, ld_data=8'h3C, en=1, j=k=8'hFF -> q=8'h3C (load wins).
//     ld_data equal to q -> chg=0.
//  5. rst=1 together with ld=1 and ld_data=8'h00 -> q=8'hA5, chg=0.
//  6. JK_STICKY_EN: a toggle on bit 2 -> sticky=8'h04, irq=1.
//     sticky_clr=8'h04 in the same cycle as a new bit-2 change -> sticky stays 8'h04.
//     sticky_clr=8'h04 alone -> sticky=0, irq=0.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK register bank.
// JK operation encoding, disable-mode selectors and the per-bit next-state function.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_op_t;

   localparam int unsigned DIS_CLEAR = 0;
   localparam int unsigned DIS_HOLD  = 1;

   function automatic logic jk_next(jk_op_t op, logic q);
      logic nxt;
      nxt = q;
      unique case (op)
         JK_HOLD: nxt = q;
         JK_RST:  nxt = 1'b0;
         JK_SET:  nxt = 1'b1;
         JK_TGL:  nxt = ~q;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK channel: state bit plus registered change pulse.
// Priority: rst > ld > en > disabled (clear or hold, per dis_mode_i).
module jk_cell
   import jk_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic rst_val_i,
   input  logic en_i,
   input  logic j_i,
   input  logic k_i,
   input  logic ld_i,
   input  logic ld_d_i,
   input  logic dis_mode_i,
   output logic q_o,
   output logic chg_o,
   output logic chg_d_o
);

   logic q_q, q_d;
   logic chg_q, chg_d;

   always_comb begin
      q_d = q_q;
      if (ld_i) begin
         q_d = ld_d_i;
      end else if (en_i) begin
         q_d = jk_next(jk_op_t'({j_i, k_i}), q_q);
      end else if (!dis_mode_i) begin
         q_d = 1'b0;
      end
      chg_d = q_d ^ q_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q   <= rst_val_i;
         chg_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         chg_q <= chg_d;
      end
   end

   assign q_o     = q_q;
   assign chg_o   = chg_q;
   assign chg_d_o = chg_d;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with parallel load, complementary output and change pulses.
// Optional sticky change flags and irq are built when JK_STICKY_EN is defined.
module jk_reg_bank
   import jk_pkg::*;
#(
   parameter int unsigned       WIDTH    = 8,
   parameter logic [WIDTH-1:0]  RST_VAL  = '0,
   parameter int unsigned       DIS_MODE = DIS_CLEAR
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] j_i,
   input  logic [WIDTH-1:0] k_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] ld_data_i,
`ifdef JK_STICKY_EN
   input  logic [WIDTH-1:0] sticky_clr_i,
   output logic [WIDTH-1:0] sticky_o,
   output logic             irq_o,
`endif
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] qbar_o,
   output logic [WIDTH-1:0] chg_o
);

   localparam logic DisHold = (DIS_MODE == DIS_HOLD);

`ifdef JK_STICKY_EN
   logic [WIDTH-1:0] chg_next;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .rst_val_i  (RST_VAL[i]),
         .en_i       (en_i),
         .j_i        (j_i[i]),
         .k_i        (k_i[i]),
         .ld_i       (ld_i),
         .ld_d_i     (ld_data_i[i]),
         .dis_mode_i (DisHold),
         .q_o        (q_o[i]),
         .chg_o      (chg_o[i]),
`ifdef JK_STICKY_EN
         .chg_d_o    (chg_next[i])
`else
         .chg_d_o    ()
`endif
      );
   end

   // Derived, never stored, so q and qbar can never disagree.
   assign qbar_o = ~q_o;

`ifdef JK_STICKY_EN
   logic [WIDTH-1:0] sticky_q, sticky_d;

   // A new change wins over a simultaneous write-1-to-clear.
   always_comb begin
      sticky_d = (sticky_q & ~sticky_clr_i) | chg_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_o = sticky_q;
   assign irq_o    = |sticky_q;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: two instances (clear-on-disable and hold-on-disable).
// Sticky/irq checks are compiled only when JK_STICKY_EN is defined.
module tb_jk_reg_bank;

   logic       clk = 1'b0;
   logic       rst, en, ld;
   logic [7:0] j, k, ld_data;
   logic [7:0] q0, qbar0, chg0, q1, qbar1, chg1;
`ifdef JK_STICKY_EN
   logic [7:0] sticky_clr, sticky0, sticky1;
   logic       irq0, irq1;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .DIS_MODE(0)) dut0 (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .j_i          (j),
      .k_i          (k),
      .ld_i         (ld),
      .ld_data_i    (ld_data),
`ifdef JK_STICKY_EN
      .sticky_clr_i (sticky_clr),
      .sticky_o     (sticky0),
      .irq_o        (irq0),
`endif
      .q_o          (q0),
      .qbar_o       (qbar0),
      .chg_o        (chg0)
   );

   jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .DIS_MODE(1)) dut1 (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .j_i          (j),
      .k_i          (k),
      .ld_i         (ld),
      .ld_data_i    (ld_data),
`ifdef JK_STICKY_EN
      .sticky_clr_i (sticky_clr),
      .sticky_o     (sticky1),
      .irq_o        (irq1),
`endif
      .q_o          (q1),
      .qbar_o       (qbar1),
      .chg_o        (chg1)
   );

   // Apply the currently driven inputs across one posedge; sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; ld = 1'b0; j = 8'h00; k = 8'h00; ld_data = 8'h00;
`ifdef JK_STICKY_EN
      sticky_clr = 8'h00;
`endif
      tick();
      tick();
      vectors++; if (q0 !== 8'hA5) begin miscompares++;
         $display("FAIL reset_q0 got %h want a5", q0); end
      vectors++; if (qbar0 !== 8'h5A) begin miscompares++;
         $display("FAIL reset_qbar0 got %h want 5a", qbar0); end
      vectors++; if (chg0 !== 8'h00) begin miscompares++;
         $display("FAIL reset_chg0 got %h want 00", chg0); end
      vectors++; if (q1 !== 8'hA5 || chg1 !== 8'h00) begin miscompares++;
         $display("FAIL reset_dut1 got q=%h chg=%h want a5/00", q1, chg1); end
`ifdef JK_STICKY_EN
      vectors++; if (sticky0 !== 8'h00 || irq0 !== 1'b0) begin miscompares++;
         $display("FAIL reset_sticky got %h irq=%b want 00/0", sticky0, irq0); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_jk();
      en = 1'b1; j = 8'hF0; k = 8'h0F;
      tick();
      vectors++; if (q0 !== 8'hF0 || chg0 !== 8'h55) begin miscompares++;
         $display("FAIL jk_setclr got q=%h chg=%h want f0/55", q0, chg0); end
      vectors++; if (qbar0 !== 8'h0F) begin miscompares++;
         $display("FAIL jk_qbar got %h want 0f", qbar0); end
      j = 8'hFF; k = 8'hFF;
      tick();
      vectors++; if (q0 !== 8'h0F || chg0 !== 8'hFF) begin miscompares++;
         $display("FAIL jk_toggle got q=%h chg=%h want 0f/ff", q0, chg0); end
      vectors++; if (q1 !== 8'h0F || chg1 !== 8'hFF) begin miscompares++;
         $display("FAIL jk_toggle_dut1 got q=%h chg=%h want 0f/ff", q1, chg1); end
      j = 8'h00; k = 8'h00;
      tick();
      vectors++; if (q0 !== 8'h0F || chg0 !== 8'h00) begin miscompares++;
         $display("FAIL jk_hold got q=%h chg=%h want 0f/00", q0, chg0); end
   endtask

   task automatic test_disable();
      en = 1'b0; j = 8'hFF; k = 8'h00;
      tick();
      vectors++; if (q0 !== 8'h00 || chg0 !== 8'h0F) begin miscompares++;
         $display("FAIL dis_clear got q=%h chg=%h want 00/0f", q0, chg0); end
      vectors++; if (q1 !== 8'h0F || chg1 !== 8'h00) begin miscompares++;
         $display("FAIL dis_hold got q=%h chg=%h want 0f/00", q1, chg1); end
      tick();
      vectors++; if (q0 !== 8'h00 || chg0 !== 8'h00) begin miscompares++;
         $display("FAIL dis_clear_again got q=%h chg=%h want 00/00", q0, chg0); end
      vectors++; if (qbar1 !== 8'hF0) begin miscompares++;
         $display("FAIL dis_hold_qbar got %h want f0", qbar1); end
   endtask

   task automatic test_load();
      ld = 1'b1; ld_data = 8'h3C; en = 1'b1; j = 8'hFF; k = 8'hFF;
      tick();
      vectors++; if (q0 !== 8'h3C || chg0 !== 8'h3C) begin miscompares++;
         $display("FAIL load_dut0 got q=%h chg=%h want 3c/3c", q0, chg0); end
      vectors++; if (q1 !== 8'h3C || chg1 !== 8'h33) begin miscompares++;
         $display("FAIL load_dut1 got q=%h chg=%h want 3c/33", q1, chg1); end
      en = 1'b0;
      tick();
      vectors++; if (q0 !== 8'h3C || chg0 !== 8'h00) begin miscompares++;
         $display("FAIL load_same got q=%h chg=%h want 3c/00", q0, chg0); end
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; ld = 1'b1; ld_data = 8'h00; en = 1'b1; j = 8'hFF; k = 8'hFF;
      tick();
      vectors++; if (q0 !== 8'hA5 || chg0 !== 8'h00) begin miscompares++;
         $display("FAIL rst_over_ld got q=%h chg=%h want a5/00", q0, chg0); end
      vectors++; if (qbar0 !== 8'h5A || q1 !== 8'hA5) begin miscompares++;
         $display("FAIL rst_over_ld_qbar got qbar=%h q1=%h want 5a/a5", qbar0, q1); end
      rst = 1'b0; ld = 1'b0;
   endtask

   task automatic test_back_to_back();
      en = 1'b1; j = 8'h01; k = 8'h01;
      tick();
      vectors++; if (q0 !== 8'hA4 || chg0 !== 8'h01) begin miscompares++;
         $display("FAIL b2b_1 got q=%h chg=%h want a4/01", q0, chg0); end
      tick();
      vectors++; if (q0 !== 8'hA5 || chg0 !== 8'h01) begin miscompares++;
         $display("FAIL b2b_2 got q=%h chg=%h want a5/01", q0, chg0); end
      j = 8'h80; k = 8'h01;
      tick();
      vectors++; if (q0 !== 8'hA4 || chg0 !== 8'h01) begin miscompares++;
         $display("FAIL b2b_3 got q=%h chg=%h want a4/01", q0, chg0); end
   endtask

`ifdef JK_STICKY_EN
   task automatic test_sticky();
      en = 1'b1; j = 8'h04; k = 8'h04; sticky_clr = 8'h00;
      tick();
      vectors++; if (q0 !== 8'hA1 || sticky0 !== 8'h04 || irq0 !== 1'b1) begin miscompares++;
         $display("FAIL sticky_set got q=%h sticky=%h irq=%b want a1/04/1", q0, sticky0, irq0);
      end
      sticky_clr = 8'h04;
      tick();
      vectors++; if (sticky0 !== 8'h04 || irq0 !== 1'b1) begin miscompares++;
         $display("FAIL sticky_set_wins got %h irq=%b want 04/1", sticky0, irq0); end
      j = 8'h00; k = 8'h00;
      tick();
      vectors++; if (sticky0 !== 8'h00 || irq0 !== 1'b0) begin miscompares++;
         $display("FAIL sticky_clear got %h irq=%b want 00/0", sticky0, irq0); end
      vectors++; if (sticky1 !== 8'h00 || irq1 !== 1'b0) begin miscompares++;
         $display("FAIL sticky_clear_dut1 got %h irq=%b want 00/0", sticky1, irq1); end
      sticky_clr = 8'h00;
   endtask
`endif

   initial begin
      test_reset();
      test_jk();
      test_disable();
      test_load();
      test_reset_priority();
      test_back_to_back();
`ifdef JK_STICKY_EN
      test_reset();
      test_sticky();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
